// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   8N1 UART receiver feeding a small first-word-fall-through receive FIFO.
//   Bit timing comes straight from the uart_freq divisor register, clamped
//   to MIN_DIV and latched at the start of every frame.
//
// Optional build macro: UART_RX_PARITY_EN
//   Defined   -> a PARITY state (even parity) follows bit 7 and the
//                parity_err output port is added; bad-parity bytes are dropped.
//   Undefined -> pure 8N1, no parity_err port.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   uart_freq  clocks per UART bit (divisor)
//   rx         asynchronous serial input, idle high
//   rd_en      pop request; ignored while the FIFO is empty
//   rd_data    FIFO head byte, 0 when empty
//   rd_valid   FIFO not empty
//   busy       receiver is mid-frame
//   frame_err  one-cycle pulse when the stop bit samples low
//   overrun    sticky, a received byte was lost to a full FIFO
//   ovr_clr    clears overrun (a coincident set wins)
//   parity_err (parity build only) one-cycle pulse on parity mismatch
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MIN_DIV    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] uart_freq,
  input  logic        rx,
  input  logic        rd_en,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        frame_err,
  output logic        overrun,
  input  logic        ovr_clr
`ifdef UART_RX_PARITY_EN
  ,
  output logic        parity_err
`endif
);

  localparam int unsigned AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_sync1;
  logic        r_rx_s;
  logic [31:0] r_cnt;
  logic [31:0] r_div_q;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
`ifdef UART_RX_PARITY_EN
  logic        r_par;
`endif

  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  logic          r_overrun;

  logic [31:0] w_div;
  logic        w_tick;
  logic        w_stop_smp;
  logic        w_par_bad;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_wr;
  logic        w_ovf;

  // ---------------------------------------------------------------- sync
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rx_s  <= r_sync1;
    end
  end

  assign w_div  = (uart_freq < 32'(MIN_DIV)) ? 32'(MIN_DIV) : uart_freq;
  assign w_tick = (r_cnt == '0);

  // ---------------------------------------------------------------- FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------- FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (!r_rx_s) w_state_nxt = S_START;
      S_START:  if (w_tick) w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
      S_DATA:   if (w_tick && (r_idx == 3'd7)) w_state_nxt = S_PARITY;
      S_PARITY: if (w_tick) w_state_nxt = S_STOP;
`else
      S_DATA:   if (w_tick && (r_idx == 3'd7)) w_state_nxt = S_STOP;
`endif
      S_STOP:   if (w_tick) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FSM outputs
`ifdef UART_RX_PARITY_EN
  assign w_par_bad = ^{r_shift, r_par};
`else
  assign w_par_bad = 1'b0;
`endif

  always_comb begin
    busy       = (r_state != S_IDLE);
    w_stop_smp = (r_state == S_STOP) && w_tick && !reset;
    w_push     = w_stop_smp && r_rx_s && !w_par_bad;
    frame_err  = w_stop_smp && !r_rx_s;
`ifdef UART_RX_PARITY_EN
    parity_err = w_stop_smp && w_par_bad;
`endif
  end

  // ---------------------------------------------------------------- bit timing / shift datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_div_q <= '0;
      r_idx   <= '0;
      r_shift <= '0;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            // Half a bit to reach the middle of the start bit.
            r_cnt   <= (w_div >> 1) - 32'd1;
            r_div_q <= w_div;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_cnt <= r_div_q - 32'd1;
            r_idx <= '0;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_shift <= {r_rx_s, r_shift[7:1]};
            r_cnt   <= r_div_q - 32'd1;
            r_idx   <= r_idx + 3'd1;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_tick) begin
            r_par <= r_rx_s;
            r_cnt <= r_div_q - 32'd1;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
`endif
        S_STOP: begin
          if (!w_tick) r_cnt <= r_cnt - 32'd1;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // ---------------------------------------------------------------- FIFO
  assign w_pop  = rd_en && (r_count != '0);
  assign w_full = (r_count == (AW+1)'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot the push needs when full.
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_ovf  = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_tail] <= r_shift;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr)  r_tail <= (r_tail == AW'(FIFO_DEPTH - 1)) ? '0 : r_tail + AW'(1);
      if (w_pop) r_head <= (r_head == AW'(FIFO_DEPTH - 1)) ? '0 : r_head + AW'(1);
      if (w_wr && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_wr && w_pop) r_count <= r_count - (AW+1)'(1);
      if (w_ovf)        r_overrun <= 1'b1;
      else if (ovr_clr) r_overrun <= 1'b0;
    end
  end

  always_comb begin
    rd_valid = (r_count != '0);
    rd_data  = rd_valid ? r_mem[r_head] : '0;
    overrun  = r_overrun;
  end

endmodule
